// File: rtl/image_sharpen_3x3_if.sv
// Pixel stream bundle for the 3x3 sharpen filter: accepted-pixel handshake in,
// one-cycle-qualified result out.
interface image_sharpen_3x3_if #(
    parameter int DW = 8
);
    logic [DW-1:0] in_img;
    logic          in_en;
    logic          in_rdy;
    logic [DW-1:0] out_img;
    logic          en_out;

    modport master (output in_img, in_en, input in_rdy, out_img, en_out);
    modport slave  (input in_img, in_en, output in_rdy, out_img, en_out);
endinterface

// File: rtl/image_sharpen_3x3.sv
// Streaming 3x3 Laplacian (4C - N - S - E - W) with zero padding and 8-bit clamp.
// Two row-length shift lines form the window; a WIDTH-cycle flush drains the last row.
module image_sharpen_3x3 #(
    parameter int WIDTH  = 128,
    parameter int HEIGHT = 128,
    parameter int DW     = 8
)(
    input  logic                clk,
    input  logic                rst_n,
    image_sharpen_3x3_if.slave  bus
);
    localparam int NPIX = WIDTH * HEIGHT;
    localparam int PW   = $clog2(NPIX);
    localparam int CW   = $clog2(WIDTH);
    localparam int RW   = $clog2(HEIGHT);
    localparam int SW   = DW + 3;

    typedef enum logic [1:0] {FILL, RUN, FLUSH} state_t;
    state_t r_state, w_state_nxt;

    logic [PW-1:0]            r_pix_cnt;
    logic [CW-1:0]            r_fcnt;
    logic [CW-1:0]            r_ocol;
    logic [RW-1:0]            r_orow;
    logic [WIDTH-1:0][DW-1:0] r_lb0;
    logic [WIDTH-1:0][DW-1:0] r_lb1;
    logic [DW-1:0]            r_c, r_n, r_s, r_e, r_w;
    logic [1:0]               r_vld_pipe;
    logic [DW-1:0]            r_out;

    logic                     w_rdy, w_acc, w_adv, w_prod;
    logic                     w_fill_done, w_last_pix, w_flush_done;
    logic                     w_col_last, w_row_last;
    logic [DW-1:0]            w_px;
    logic signed [SW-1:0]     w_res;
    logic [DW-1:0]            w_clamp;

    assign w_rdy        = (r_state != FLUSH);
    assign w_acc        = bus.in_en && w_rdy;
    assign w_adv        = w_acc || (r_state == FLUSH);
    assign w_prod       = w_adv && (r_state != FILL);
    assign w_px         = (r_state == FLUSH) ? '0 : bus.in_img;
    assign w_fill_done  = (r_pix_cnt == PW'(WIDTH - 1));
    assign w_last_pix   = (r_pix_cnt == PW'(NPIX - 1));
    assign w_flush_done = (r_fcnt == CW'(WIDTH - 1));
    assign w_col_last   = (r_ocol == CW'(WIDTH - 1));
    assign w_row_last   = (r_orow == RW'(HEIGHT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= FILL;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            FILL:    if (w_acc && w_fill_done) w_state_nxt = RUN;
            RUN:     if (w_acc && w_last_pix)  w_state_nxt = FLUSH;
            FLUSH:   if (w_flush_done)         w_state_nxt = FILL;
            default: w_state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pix_cnt <= '0;
            r_fcnt    <= '0;
            r_ocol    <= '0;
            r_orow    <= '0;
        end else begin
            if (w_acc)
                r_pix_cnt <= w_last_pix ? '0 : r_pix_cnt + 1'b1;
            if (r_state == FLUSH)
                r_fcnt <= w_flush_done ? '0 : r_fcnt + 1'b1;
            // Output position tracks the window centre; it alone decides padding.
            if (w_prod) begin
                r_ocol <= w_col_last ? '0 : r_ocol + 1'b1;
                if (w_col_last)
                    r_orow <= w_row_last ? '0 : r_orow + 1'b1;
            end
        end
    end

    // Index 0 is the newest pixel: lb0[WIDTH-1] is one row back, lb1 continues it.
    always_ff @(posedge clk) begin
        if (w_adv) begin
            r_lb0 <= {r_lb0[WIDTH-2:0], w_px};
            r_lb1 <= {r_lb1[WIDTH-2:0], r_lb0[WIDTH-1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_c <= '0;
            r_n <= '0;
            r_s <= '0;
            r_e <= '0;
            r_w <= '0;
        end else if (w_prod) begin
            r_c <= r_lb0[WIDTH-1];
            r_e <= w_col_last         ? '0 : r_lb0[WIDTH-2];
            r_w <= (r_ocol == '0)     ? '0 : r_lb1[0];
            r_n <= (r_orow == '0)     ? '0 : r_lb1[WIDTH-1];
            r_s <= w_row_last         ? '0 : w_px;
        end
    end

    always_comb begin
        w_res = $signed({1'b0, r_c, 2'b00})
              - $signed({3'b000, r_n}) - $signed({3'b000, r_s})
              - $signed({3'b000, r_e}) - $signed({3'b000, r_w});
        w_clamp = w_res[DW-1:0];
        if (w_res[SW-1])
            w_clamp = '0;
        else if (|w_res[SW-2:DW])
            w_clamp = '1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_pipe <= '0;
            r_out      <= '0;
        end else begin
            r_vld_pipe <= {r_vld_pipe[0], w_prod};
            if (r_vld_pipe[0])
                r_out <= w_clamp;
        end
    end

    assign bus.in_rdy  = w_rdy;
    assign bus.out_img = r_out;
    assign bus.en_out  = r_vld_pipe[1];
endmodule

// File: tb/tb_image_sharpen_3x3.sv
// Scoreboard bench: an 8x8 instance for directed patterns and stalls, a 128x128
// instance for latency, flush length and mid-frame reset.
module tb_image_sharpen_3x3;
    localparam int SWD = 8, SHT = 8, BWD = 128, BHT = 128;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    image_sharpen_3x3_if #(.DW(8)) bus_s();
    image_sharpen_3x3_if #(.DW(8)) bus_b();

    image_sharpen_3x3 #(.WIDTH(SWD), .HEIGHT(SHT), .DW(8)) u_small (
        .clk(clk), .rst_n(rst_n), .bus(bus_s));
    image_sharpen_3x3 #(.WIDTH(BWD), .HEIGHT(BHT), .DW(8)) u_big (
        .clk(clk), .rst_n(rst_n), .bus(bus_b));

    logic [7:0] d_img = 8'd0;
    logic       d_en = 1'b0;
    int         sel = 0;
    assign bus_s.in_img = d_img;
    assign bus_b.in_img = d_img;
    assign bus_s.in_en  = d_en && (sel == 0);
    assign bus_b.in_en  = d_en && (sel == 1);

    int n_tests = 0, n_fail = 0;
    int cyc = 0;
    int pulses_s = 0, pulses_b = 0;
    int first_b = -1, first_acc = 0;
    logic [7:0] q_s[$];
    logic [7:0] q_b[$];
    logic [7:0] img [0:BWD*BHT-1];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int got, input int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s got=%0d want=%0d (t=%0t)", nm, got, want, $time);
        end
    endtask

    always @(negedge clk) begin
        if (bus_s.en_out === 1'b1) begin
            pulses_s++;
            if (q_s.size() == 0) chk("small_extra_pulse", 1, 0);
            else chk("small_pixel", int'(bus_s.out_img), int'(q_s.pop_front()));
        end
        if (bus_b.en_out === 1'b1) begin
            pulses_b++;
            if (first_b < 0) first_b = cyc;
            if (q_b.size() == 0) chk("big_extra_pulse", 1, 0);
            else chk("big_pixel", int'(bus_b.out_img), int'(q_b.pop_front()));
        end
    end

    function automatic void push(input int v);
        if (sel == 0) q_s.push_back(8'(v));
        else          q_b.push_back(8'(v));
    endfunction

    // Constant 100: corners 400-200, edges 400-300, interior 0.
    function automatic void push_const(input int w, input int h);
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++) begin
                int nb;
                nb = ((r == 0 || r == h-1) ? 1 : 0) + ((c == 0 || c == w-1) ? 1 : 0);
                push(nb == 2 ? 200 : (nb == 1 ? 100 : 0));
            end
    endfunction

    function automatic void push_spot(input int w, input int h, input int sr, input int sc, input int v);
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++)
                push((r == sr && c == sc) ? v : 0);
    endfunction

    function automatic int pix(input int w, input int h, input int r, input int c);
        if (r < 0 || r >= h || c < 0 || c >= w) return 0;
        return int'(img[r*w + c]);
    endfunction

    function automatic void push_model(input int w, input int h);
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++) begin
                int v;
                v = 4*pix(w,h,r,c) - pix(w,h,r-1,c) - pix(w,h,r+1,c)
                  - pix(w,h,r,c-1) - pix(w,h,r,c+1);
                push(v < 0 ? 0 : (v > 255 ? 255 : v));
            end
    endfunction

    task automatic send(input logic [7:0] px, input int stall_pct, input bit chk_idle);
        int  g;
        bit  r;
        g = 0;
        while (stall_pct > 0 && $urandom_range(99, 0) < stall_pct) begin
            d_en = 1'b0;
            @(negedge clk);
            if (chk_idle) chk("fill_stall_quiet", int'(bus_s.en_out), 0);
            @(posedge clk); #1;
        end
        d_img = px;
        d_en  = 1'b1;
        do begin
            @(negedge clk);
            r = (sel == 0) ? bus_s.in_rdy : bus_b.in_rdy;
            @(posedge clk); #1;
            g++;
        end while (!r && g < 1000);
        if (!r) chk("accept_timeout", 0, 1);
        d_en = 1'b0;
    endtask

    task automatic drive_frame(input int w, input int stall, input int upto);
        for (int k = 0; k < upto; k++) begin
            send(img[k], stall, stall > 0 && k < w);
            if (k == 0) first_acc = cyc;
        end
    endtask

    task automatic drain();
        int g;
        g = 0;
        while ((q_s.size() != 0 || q_b.size() != 0) && g < 2000) begin
            @(posedge clk); #1;
            g++;
        end
        repeat (4) @(posedge clk);
        #1;
        chk("drain_small", q_s.size(), 0);
        chk("drain_big", q_b.size(), 0);
    endtask

    initial begin
        int cnt;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_small_en", int'(bus_s.en_out), 0);
        chk("rst_small_img", int'(bus_s.out_img), 0);
        chk("rst_small_rdy", int'(bus_s.in_rdy), 1);
        chk("rst_big_en", int'(bus_b.en_out), 0);
        chk("rst_big_rdy", int'(bus_b.in_rdy), 1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Three back-to-back 8x8 frames: constant, spot 255 at (3,3), spot 50 at (0,0).
        sel = 0;
        pulses_s = 0;
        for (int k = 0; k < 64; k++) img[k] = 8'd100;
        push_const(SWD, SHT);
        drive_frame(SWD, 0, 64);
        for (int k = 0; k < 64; k++) img[k] = 8'd0;
        img[3*SWD + 3] = 8'd255;
        push_spot(SWD, SHT, 3, 3, 255);
        drive_frame(SWD, 0, 64);
        for (int k = 0; k < 64; k++) img[k] = 8'd0;
        img[0] = 8'd50;
        push_spot(SWD, SHT, 0, 0, 200);
        drive_frame(SWD, 0, 64);
        drain();
        chk("small_pulses_3frames", pulses_s, 192);

        // Random frame, continuous then with ~30% stalls; both must match the model.
        for (int k = 0; k < 64; k++) img[k] = 8'($urandom_range(255, 0));
        pulses_s = 0;
        push_model(SWD, SHT);
        drive_frame(SWD, 0, 64);
        drain();
        push_model(SWD, SHT);
        drive_frame(SWD, 30, 64);
        drain();
        chk("small_pulses_rand", pulses_s, 128);

        // 128x128 constant frame: first result latency and flush length.
        sel = 1;
        for (int k = 0; k < BWD*BHT; k++) img[k] = 8'd100;
        pulses_b = 0;
        first_b  = -1;
        push_const(BWD, BHT);
        drive_frame(BWD, 0, BWD*BHT);
        cnt = 0;
        for (int g = 0; g < 1000; g++) begin
            @(negedge clk);
            if (bus_b.in_rdy) break;
            cnt++;
        end
        chk("flush_rdy_low_cycles", cnt, 128);
        drain();
        chk("first_en_latency", first_b - first_acc, 129);
        chk("big_pulses_const", pulses_b, BWD*BHT);

        // Reset at pixel 500 of a random frame, then a full fresh frame.
        for (int k = 0; k < BWD*BHT; k++) img[k] = 8'($urandom_range(255, 0));
        push_model(BWD, BHT);
        drive_frame(BWD, 0, 500);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_en_async", int'(bus_b.en_out), 0);
        chk("midrst_img_async", int'(bus_b.out_img), 0);
        chk("midrst_rdy", int'(bus_b.in_rdy), 1);
        repeat (2) begin
            @(negedge clk);
            chk("midrst_en_hold", int'(bus_b.en_out), 0);
            chk("midrst_img_hold", int'(bus_b.out_img), 0);
        end
        q_b.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < BWD*BHT; k++) img[k] = 8'($urandom_range(255, 0));
        pulses_b = 0;
        push_model(BWD, BHT);
        drive_frame(BWD, 0, BWD*BHT);
        drain();
        chk("big_pulses_after_rst", pulses_b, BWD*BHT);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
